univ_shift_reg: RTL and testbench

Parametrised universal shift register for the datapath. It holds, parallel-loads, shifts left or right, and optionally rotates, all gated by a clock enable. A built-in serializer sequence loads a word on `start` and shifts it out over DW enabled cycles, with `busy`/`done` status. It is the general-purpose register slice used wherever serial/parallel conversion or multi-mode storage is needed.

---
 rtl/univ_shift_pkg.sv | 27 ++
 rtl/shift_bit_cnt.sv | 29 ++
 rtl/univ_shift_reg.sv | 97 +++++++++
 tb/tb_univ_shift_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// Shared types and mode codes for the universal shift register slice.
// Rotate modes are only decoded when UNIV_SHIFT_ROTATE_EN is defined.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROTL = 3'd4,
    ROTR = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROTL = 3'd4;
  localparam logic [2:0] MODE_ROTR = 3'd5;

endpackage

// File: rtl/shift_bit_cnt.sv
// Serializer bit counter: counts enabled shifts and flags the last one (DW-1).
module shift_bit_cnt #(
  parameter int DW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/load/shift modes and a built-in serializer.
// Define UNIV_SHIFT_ROTATE_EN to enable the ROTL/ROTR modes (otherwise they hold).
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int DW        = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic [2:0]    mode,
  input  logic          start,
  input  logic          sin_r,
  input  logic          sin_l,
  input  logic [DW-1:0] inp,
  output logic [DW-1:0] out,
  output logic          sout_msb,
  output logic          sout_lsb,
  output logic          busy,
  output logic          done
);

  state_e        state;
  logic [DW-1:0] mode_nxt;
  logic [DW-1:0] ser_nxt;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          cnt_tc;

  always_comb begin
    mode_nxt = out;
    case (mode)
      MODE_LOAD: mode_nxt = inp;
      MODE_SHL:  mode_nxt = {out[DW-2:0], sin_r};
      MODE_SHR:  mode_nxt = {sin_l, out[DW-1:1]};
`ifdef UNIV_SHIFT_ROTATE_EN
      MODE_ROTL: mode_nxt = {out[DW-2:0], out[DW-1]};
      MODE_ROTR: mode_nxt = {out[0], out[DW-1:1]};
`endif
      default:   mode_nxt = out;
    endcase
  end

  assign ser_nxt = MSB_FIRST ? {out[DW-2:0], sin_r} : {sin_l, out[DW-1:1]};

  // Counter restarts on start and wraps to zero on the last shift so it never exceeds DW-1
  assign cnt_clr = enb && (((state == ST_IDLE) && start) || ((state == ST_RUN) && cnt_tc));
  assign cnt_inc = enb && (state == ST_RUN);

  shift_bit_cnt #(
    .DW (DW)
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enb) begin
            if (start) begin
              out   <= inp;
              state <= ST_RUN;
            end else begin
              out <= mode_nxt;
            end
          end
        end
        ST_RUN: begin
          if (enb) begin
            out <= ser_nxt;
            if (cnt_tc) begin
              state <= ST_DONE;
            end
          end
        end
        // DONE is a single-cycle status slot and ignores enb
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sout_msb = out[DW-1];
  assign sout_lsb = out[0];
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (DW=8, MSB_FIRST=1); honours UNIV_SHIFT_ROTATE_EN.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [2:0] mode;
  logic       start;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] inp;
  logic [7:0] out;
  logic       sout_msb;
  logic       sout_lsb;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  univ_shift_reg #(
    .DW        (8),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .mode     (mode),
    .start    (start),
    .sin_r    (sin_r),
    .sin_l    (sin_l),
    .inp      (inp),
    .out      (out),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one serializer sequence over a fixed 20-cycle window; stall bit c drops enb before edge c.
  task automatic run_ser(input logic [7:0] d, input logic [19:0] stall,
                         output logic [7:0] stream, output int nbits,
                         output int busy_cnt, output int done_cnt);
    logic en_at_edge;
    stream = 8'h00; nbits = 0; busy_cnt = 0; done_cnt = 0;
    sin_r = 1'b0; start = 1'b1; inp = d;
    for (int c = 0; c < 20; c++) begin
      enb        = !stall[c];
      en_at_edge = enb;
      mode       = c[0] ? MODE_LOAD : MODE_SHR;
      if (c != 0) inp = ~d;
      tick();
      start = 1'b0;
      if (busy && en_at_edge) begin
        stream = {stream[6:0], sout_msb};
        nbits++;
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    enb = 1'b1; mode = MODE_HOLD;
  endtask

  task automatic test_reset();
    rst = 1'b1; enb = 1'b0; mode = MODE_HOLD; start = 1'b0;
    sin_r = 1'b0; sin_l = 1'b0; inp = 8'h00;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h expected 00", out); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_status: got busy=%b done=%b expected 0/0", busy, done); end
    tick();
    rst = 1'b1;
    // Mid-activity: load, start, shift twice, then assert reset between edges
    enb = 1'b1; inp = 8'hA5; mode = MODE_LOAD;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL reset_async_out: got %h expected 00", out); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_async_status: got busy=%b done=%b expected 0/0", busy, done); end
    tick();
    rst = 1'b1;
    mode = MODE_HOLD;
  endtask

  task automatic test_modes();
    enb = 1'b1; start = 1'b0;
    mode = MODE_LOAD; inp = 8'hA5;
    tick();
    n_checks++; if (out !== 8'hA5) begin n_fail++; $display("FAIL mode_load: got %h expected a5", out); end
    mode = MODE_SHL; sin_r = 1'b1;
    tick();
    n_checks++; if (out !== 8'h4B) begin n_fail++; $display("FAIL mode_shl: got %h expected 4b", out); end
    mode = MODE_SHR; sin_l = 1'b0;
    tick();
    n_checks++; if (out !== 8'h25) begin n_fail++; $display("FAIL mode_shr: got %h expected 25", out); end
    n_checks++; if (sout_msb !== 1'b0 || sout_lsb !== 1'b1) begin n_fail++; $display("FAIL sout_taps: got msb=%b lsb=%b expected 0/1", sout_msb, sout_lsb); end
    enb = 1'b0; mode = MODE_LOAD; inp = 8'hFF;
    tick();
    n_checks++; if (out !== 8'h25) begin n_fail++; $display("FAIL enb_low_load: got %h expected 25", out); end
    enb = 1'b1; mode = MODE_HOLD;
    tick();
    n_checks++; if (out !== 8'h25) begin n_fail++; $display("FAIL mode_hold: got %h expected 25", out); end
    mode = 3'd6;
    tick();
    n_checks++; if (out !== 8'h25) begin n_fail++; $display("FAIL mode_code6: got %h expected 25", out); end
    mode = 3'd7; sin_l = 1'b1;
    tick();
    n_checks++; if (out !== 8'h25) begin n_fail++; $display("FAIL mode_code7: got %h expected 25", out); end
    sin_r = 1'b0; sin_l = 1'b0; mode = MODE_HOLD;
  endtask

  task automatic test_rotate();
    logic [7:0] exp_l;
    logic [7:0] exp_r;
`ifdef UNIV_SHIFT_ROTATE_EN
    exp_l = 8'h03; exp_r = 8'hC0;
`else
    exp_l = 8'h81; exp_r = 8'h81;
`endif
    enb = 1'b1; start = 1'b0; mode = MODE_LOAD; inp = 8'h81;
    tick();
    mode = MODE_ROTL;
    tick();
    n_checks++; if (out !== exp_l) begin n_fail++; $display("FAIL rotl: got %h expected %h", out, exp_l); end
    mode = MODE_LOAD;
    tick();
    mode = MODE_ROTR;
    tick();
    n_checks++; if (out !== exp_r) begin n_fail++; $display("FAIL rotr: got %h expected %h", out, exp_r); end
    mode = MODE_HOLD;
  endtask

  task automatic test_serializer();
    logic [7:0] pat;
    logic [7:0] exp_out;
    pat = 8'hB4;
    enb = 1'b1; sin_r = 1'b0; mode = MODE_HOLD; inp = pat; start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      start = 1'b0; inp = 8'hFF;
      mode = (k % 2 == 0) ? MODE_LOAD : MODE_SHR;
      exp_out = pat << k;
      n_checks++; if (sout_msb !== pat[7-k]) begin n_fail++; $display("FAIL ser_bit%0d: got %b expected %b", k, sout_msb, pat[7-k]); end
      n_checks++; if (out !== exp_out) begin n_fail++; $display("FAIL ser_out%0d: got %h expected %h", k, out, exp_out); end
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL ser_busy%0d: got busy=%b done=%b expected 1/0", k, busy, done); end
    end
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL ser_done: got busy=%b done=%b expected 0/1", busy, done); end
    n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL ser_final_out: got %h expected 00", out); end
    // start during DONE must not relaunch the sequence
    start = 1'b1; mode = MODE_HOLD; inp = 8'h3C;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ser_start_in_done: got busy=%b done=%b expected 0/0", busy, done); end
    n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL ser_start_in_done_out: got %h expected 00", out); end
  endtask

  task automatic test_stall();
    logic [7:0] stream;
    int nbits, bcnt, dcnt;
    run_ser(8'hB4, 20'h00070, stream, nbits, bcnt, dcnt);
    n_checks++; if (stream !== 8'hB4 || nbits != 8) begin n_fail++; $display("FAIL stall_stream: got %h (%0d bits) expected b4 (8 bits)", stream, nbits); end
    n_checks++; if (bcnt != 11) begin n_fail++; $display("FAIL stall_busy_len: got %0d expected 11", bcnt); end
    n_checks++; if (dcnt != 1) begin n_fail++; $display("FAIL stall_done_cnt: got %0d expected 1", dcnt); end
  endtask

  task automatic test_abort();
    logic [7:0] stream;
    int nbits, bcnt, dcnt;
    dcnt = 0;
    enb = 1'b1; sin_r = 1'b0; mode = MODE_HOLD; inp = 8'hB4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_state: got out=%h busy=%b expected 00/0", out, busy); end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) dcnt++;
    end
    n_checks++; if (dcnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", dcnt); end
    run_ser(8'h5A, 20'h00000, stream, nbits, bcnt, dcnt);
    n_checks++; if (stream !== 8'h5A || nbits != 8) begin n_fail++; $display("FAIL abort_rerun_stream: got %h (%0d bits) expected 5a (8 bits)", stream, nbits); end
    n_checks++; if (bcnt != 8 || dcnt != 1) begin n_fail++; $display("FAIL abort_rerun_status: got busy=%0d done=%0d expected 8/1", bcnt, dcnt); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_rotate();
    test_serializer();
    test_stall();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
